fp_aligner: RTL
===============

FP_ALIGNER -- requirements
Module: fp_aligner

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-002 The module SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The module SHALL have the port in_valid, input, 1 bit: operand pair on a/b is valid.
REQ-004 The module SHALL have the port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-005 The module SHALL have the port a, input, 32 bits: IEEE-754 single-precision operand A.
REQ-006 The module SHALL have the port b, input, 32 bits: IEEE-754 single-precision operand B.
REQ-007 The module SHALL have the port out_valid, output, 1 bit: the aligned result is valid.
REQ-008 The module SHALL have the port out_ready, input, 1 bit: the consumer accepts the result.
REQ-009 The module SHALL have the port exp_out, output, 8 bits: the effective exponent of the larger operand.
REQ-010 The module SHALL have the port mant_big, output, 24 bits: the larger operand's significand including the hidden bit.
REQ-011 The module SHALL have the port mant_small, output, 24 bits: the smaller operand's significand after right-shift alignment.
REQ-012 The module SHALL have the ports guard, round and sticky, each output, 1 bit: the bits shifted out of mant_small.
REQ-013 The module SHALL have the ports sign_big and sign_small, each output, 1 bit: the signs of the larger and smaller operands.
REQ-014 The module SHALL have the port swap, output, 1 bit: 1 when B was selected as the larger operand.

Function
REQ-015 The module SHALL implement a 3-state FSM with states IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 Unpacking: the hidden bit SHALL be 1 when exp != 0; when exp == 0 the hidden bit SHALL be 0 and the effective exponent SHALL be 1.
REQ-017 Selection: B SHALL be big when {effexp_b, mant_b} > {effexp_a, mant_a}; otherwise A SHALL be big, so ties select A with swap = 0.
REQ-018 Accept: on an edge with in_valid && in_ready, the module SHALL latch the big fields, the signs and swap, load shift register sr[25:0] = {small significand, 2'b00}, clear sticky, and set cnt = min(effexp_big - effexp_small, 26).
REQ-019 After accept, the next state SHALL be DONE when cnt == 0 and SHIFT otherwise.
REQ-020 SHIFT: each edge SHALL perform sticky <= sticky | sr[0], sr <= sr >> 1 and cnt <= cnt - 1; the edge on which cnt goes 1 -> 0 SHALL move the FSM to DONE.
REQ-021 Latency: out_valid SHALL rise cnt+1 edges after the accept edge, giving 1 to 27 cycles.
REQ-022 Outputs SHALL be mant_small = sr[25:2], guard = sr[1] and round = sr[0].
REQ-023 DONE: all outputs SHALL be held stable while out_ready = 0.
REQ-024 The edge with out_valid && out_ready SHALL move the FSM to IDLE; a new accept SHALL be possible no earlier than the following edge.
REQ-025 in_valid, a and b SHALL be ignored outside IDLE.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 Exponent 0xFF (Inf/NaN) SHALL receive no special handling and SHALL be aligned arithmetically like any other value.

Reset
REQ-028 While rst_n = 0, the FSM SHALL be in IDLE, in_ready SHALL be 1, and out_valid and every data output SHALL be 0.
REQ-029 Assertion of rst_n in any state, including mid-SHIFT, SHALL abort the operation immediately with no partial result emitted.
REQ-030 Release of rst_n SHALL NOT itself produce out_valid.

Verification
REQ-031 The bench SHALL cover: a = 0x3F800000, b = 0x3F000000 -> swap = 0, exp_out = 0x7F, mant_big = 0x800000, mant_small = 0x400000, g/r/s = 0/0/0, out_valid 2 edges after accept.
REQ-032 The bench SHALL cover: a = 0x3F000000, b = 0x40000000 -> swap = 1, exp_out = 0x80, mant_small = 0x200000, sign_big = 0, out_valid 3 edges after accept.
REQ-033 The bench SHALL cover: a = b = 0x40400000 -> swap = 0, mant_big = mant_small = 0xC00000, out_valid 1 edge after accept.
REQ-034 The bench SHALL cover: a = 0x4B800000, b = 0x3F800001 (d = 24) -> mant_small = 0, guard = 1, round = 0, sticky = 1; and a = 0x7F000000, b = 0x3F800000 (d clamped to 26) -> mant_small = 0, g/r/s = 0/0/1, out_valid 27 edges after accept.
REQ-035 The bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready = 0 throughout; out_ready = 1 -> IDLE on the next edge.
REQ-036 The bench SHALL cover: rst_n pulsed low on the 3rd SHIFT cycle of the d = 24 case -> all outputs 0 at once, in_ready = 1, and no out_valid pulse after release.

Source files
------------

// File: rtl/fp_aligner.sv
// fp_aligner
// Aligns two IEEE-754 single-precision operands ahead of an adder: the
// larger operand (by effective exponent, then significand) is passed
// through unchanged, and the smaller operand's significand is shifted
// right one bit per clock until both share the larger exponent. The
// guard, round and sticky bits of the shifted significand are kept.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (a, b accepted in IDLE)
//   a, b                  : single-precision operands
//   out_valid / out_ready : result handshake (held in DONE)
//   exp_out               : effective exponent of the larger operand
//   mant_big              : larger significand including hidden bit
//   mant_small            : smaller significand after alignment
//   guard, round, sticky  : bits shifted out of mant_small
//   sign_big, sign_small  : signs of the larger / smaller operand
//   swap                  : 1 when b was chosen as the larger operand

module fp_aligner (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  exp_out,
    output logic [23:0] mant_big,
    output logic [23:0] mant_small,
    output logic        guard,
    output logic        round,
    output logic        sticky,
    output logic        sign_big,
    output logic        sign_small,
    output logic        swap
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  eff_a;
    logic [7:0]  eff_b;
    logic [23:0] sig_a;
    logic [23:0] sig_b;
    logic        b_big;
    logic [7:0]  eff_big;
    logic [7:0]  eff_small;
    logic [23:0] sig_big;
    logic [23:0] sig_small;
    logic [7:0]  diff;
    logic [4:0]  cnt_init;
    logic        accept;

    logic [25:0] sr;
    logic [4:0]  cnt;
    logic        sticky_r;

    // Denormals and zero have no hidden bit and behave as exponent 1.
    assign eff_a = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    assign eff_b = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    assign sig_a = {(a[30:23] != 8'd0), a[22:0]};
    assign sig_b = {(b[30:23] != 8'd0), b[22:0]};

    // Strict comparison so that equal magnitudes keep a as the big operand.
    assign b_big     = {eff_b, sig_b} > {eff_a, sig_a};
    assign eff_big   = b_big ? eff_b : eff_a;
    assign eff_small = b_big ? eff_a : eff_b;
    assign sig_big   = b_big ? sig_b : sig_a;
    assign sig_small = b_big ? sig_a : sig_b;
    assign diff      = eff_big - eff_small;

    // Beyond 26 positions every bit has already left sr, so more shifting
    // would only cost cycles.
    assign cnt_init  = (diff > 8'd26) ? 5'd26 : diff[4:0];

    assign accept    = in_valid && (state == IDLE);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign mant_small = sr[25:2];
    assign guard      = sr[1];
    assign round      = sr[0];
    assign sticky     = sticky_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (cnt_init == 5'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == 5'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_out    <= 8'd0;
            mant_big   <= 24'd0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            swap       <= 1'b0;
            sr         <= 26'd0;
            cnt        <= 5'd0;
            sticky_r   <= 1'b0;
        end else if (accept) begin
            exp_out    <= eff_big;
            mant_big   <= sig_big;
            sign_big   <= b_big ? b[31] : a[31];
            sign_small <= b_big ? a[31] : b[31];
            swap       <= b_big;
            sr         <= {sig_small, 2'b00};
            cnt        <= cnt_init;
            sticky_r   <= 1'b0;
        end else if (state == SHIFT) begin
            sticky_r   <= sticky_r | sr[0];
            sr         <= sr >> 1;
            cnt        <= cnt - 5'd1;
        end
    end

endmodule
